hazard_control: RTL and testbench

HAZARD_CONTROL -- requirements
Module: hazard_control

---
 rtl/hazard_control_if.sv | 48 ++++
 rtl/hazard_control.sv | 163 ++++++++++++++++
 tb/tb_hazard_control.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_control_if.sv
// Signal bundle between the pipeline and the hazard controller.
// The pipeline drives the master side; hazard_control sits on the slave side.
interface hazard_control_if;
    logic [1:0] rs_ID;
    logic [1:0] rt_ID;
    logic       use_rs_ID;
    logic       use_rt_ID;
    logic       d_readM_EX;
    logic       RegWrite_EX;
    logic [1:0] write_reg_addr_EX;
    logic       mispredict_EX;
    logic       isJump_ID;
    logic       i_mem_ready;
    logic       d_mem_req_MEM;
    logic       d_mem_ready;
    logic       is_halted_WB;

    logic       stall_PC;
    logic       stall_IF_ID;
    logic       stall_ID_EX;
    logic       stall_EX_MEM;
    logic       stall_MEM_WB;
    logic       flush_IF_ID;
    logic       flush_ID_EX;
    logic       flush_EX_MEM;
    logic       flush_MEM_WB;
    logic       pc_redirect;
    logic       halted;
    logic [1:0] state;

    modport master (
        output rs_ID, rt_ID, use_rs_ID, use_rt_ID, d_readM_EX, RegWrite_EX,
               write_reg_addr_EX, mispredict_EX, isJump_ID, i_mem_ready,
               d_mem_req_MEM, d_mem_ready, is_halted_WB,
        input  stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
               flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
               pc_redirect, halted, state
    );

    modport slave (
        input  rs_ID, rt_ID, use_rs_ID, use_rt_ID, d_readM_EX, RegWrite_EX,
               write_reg_addr_EX, mispredict_EX, isJump_ID, i_mem_ready,
               d_mem_req_MEM, d_mem_ready, is_halted_WB,
        output stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
               flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
               pc_redirect, halted, state
    );
endinterface

// File: rtl/hazard_control.sv
// Pipeline hazard controller: stall/flush arbitration with a RUN/DMEM_WAIT/HALT FSM.
// Optional hazard statistics counters are enabled with the HAZARD_STATS_EN macro.
module hazard_control (
    input  logic              clk,
    input  logic              reset,
    hazard_control_if.slave   hc
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]       mem_stall_cnt,
    output logic [15:0]       lu_stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        HALT      = 2'd2,
        HALT_ALT  = 2'd3
    } state_t;

    state_t     state_r;
    state_t     next_state_s;
    logic       halted_r;
    logic       in_halt_s;
    logic       mem_wait_s;
    logic       load_use_s;
    logic [4:0] stall_vec_s;
    logic [3:0] flush_vec_s;
    logic       redirect_s;
    logic       mem_evt_s;
    logic       lu_evt_s;
    logic       flush_evt_s;

    // Encoding 3 is never produced but decodes as HALT for robustness.
    assign in_halt_s  = (state_r == HALT) || (state_r == HALT_ALT);
    assign mem_wait_s = (state_r == DMEM_WAIT) ||
                        ((state_r == RUN) && hc.d_mem_req_MEM && !hc.d_mem_ready);
    assign load_use_s = hc.d_readM_EX && hc.RegWrite_EX &&
                        ((hc.use_rs_ID && (hc.rs_ID == hc.write_reg_addr_EX)) ||
                         (hc.use_rt_ID && (hc.rt_ID == hc.write_reg_addr_EX)));

    // Next-state logic; a WB halt wins from any state and HALT is sticky.
    always_comb begin
        next_state_s = state_r;
        if (hc.is_halted_WB) begin
            next_state_s = HALT;
        end else begin
            case (state_r)
                RUN: begin
                    if (hc.d_mem_req_MEM && !hc.d_mem_ready) begin
                        next_state_s = DMEM_WAIT;
                    end else begin
                        next_state_s = RUN;
                    end
                end
                DMEM_WAIT: begin
                    if (hc.d_mem_ready) begin
                        next_state_s = RUN;
                    end else begin
                        next_state_s = DMEM_WAIT;
                    end
                end
                default: next_state_s = HALT;
            endcase
        end
    end

    // State register and halt flag; halted rises together with the HALT state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= RUN;
            halted_r <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            halted_r <= (next_state_s == HALT);
        end
    end

    // Prioritised stall/flush selection; vectors are ordered PC..MEM_WB.
    always_comb begin
        stall_vec_s = 5'b00000;
        flush_vec_s = 4'b0000;
        redirect_s  = 1'b0;
        mem_evt_s   = 1'b0;
        lu_evt_s    = 1'b0;
        flush_evt_s = 1'b0;
        if (reset) begin
            flush_vec_s = 4'b1111;
        end else if (in_halt_s) begin
            stall_vec_s = 5'b11111;
        end else if (mem_wait_s) begin
            stall_vec_s = 5'b11110;
            flush_vec_s = 4'b0001;
            mem_evt_s   = 1'b1;
        end else if (hc.mispredict_EX) begin
            flush_vec_s = 4'b1100;
            redirect_s  = 1'b1;
            flush_evt_s = 1'b1;
        end else if (load_use_s) begin
            stall_vec_s = 5'b11000;
            flush_vec_s = 4'b0100;
            lu_evt_s    = 1'b1;
        end else if (hc.isJump_ID) begin
            flush_vec_s = 4'b1000;
            flush_evt_s = 1'b1;
        end else if (!hc.i_mem_ready) begin
            stall_vec_s = 5'b10000;
            flush_vec_s = 4'b1000;
        end else begin
            redirect_s  = 1'b0;
        end
    end

    assign hc.stall_PC     = stall_vec_s[4];
    assign hc.stall_IF_ID  = stall_vec_s[3];
    assign hc.stall_ID_EX  = stall_vec_s[2];
    assign hc.stall_EX_MEM = stall_vec_s[1];
    assign hc.stall_MEM_WB = stall_vec_s[0];
    assign hc.flush_IF_ID  = flush_vec_s[3];
    assign hc.flush_ID_EX  = flush_vec_s[2];
    assign hc.flush_EX_MEM = flush_vec_s[1];
    assign hc.flush_MEM_WB = flush_vec_s[0];
    assign hc.pc_redirect  = redirect_s;
    assign hc.halted       = halted_r;
    assign hc.state        = state_r;

`ifdef HAZARD_STATS_EN
    logic [15:0] mem_stall_cnt_r;
    logic [15:0] lu_stall_cnt_r;
    logic [15:0] flush_cnt_r;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF)) begin
            sat_inc = v + 16'd1;
        end else begin
            sat_inc = v;
        end
    endfunction

    // Saturating event counters, frozen while halted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_stall_cnt_r <= 16'd0;
            lu_stall_cnt_r  <= 16'd0;
            flush_cnt_r     <= 16'd0;
        end else if (!in_halt_s) begin
            mem_stall_cnt_r <= sat_inc(mem_stall_cnt_r, mem_evt_s);
            lu_stall_cnt_r  <= sat_inc(lu_stall_cnt_r, lu_evt_s);
            flush_cnt_r     <= sat_inc(flush_cnt_r, flush_evt_s);
        end else begin
            mem_stall_cnt_r <= mem_stall_cnt_r;
            lu_stall_cnt_r  <= lu_stall_cnt_r;
            flush_cnt_r     <= flush_cnt_r;
        end
    end

    assign mem_stall_cnt = mem_stall_cnt_r;
    assign lu_stall_cnt  = lu_stall_cnt_r;
    assign flush_cnt     = flush_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Scoreboard bench for hazard_control: directed scenarios plus random traffic
// checked against a cause-based reference model.
module tb_hazard_control;

    typedef struct packed {
        logic       reset;
        logic [1:0] rs;
        logic [1:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       d_read;
        logic       reg_write;
        logic [1:0] wr;
        logic       misp;
        logic       jump;
        logic       imem_ready;
        logic       req;
        logic       dready;
        logic       halt_wb;
    } stim_t;

    typedef struct packed {
        logic [9:0]  outs;
        logic [1:0]  st;
        logic        hl;
        logic [15:0] c_mem;
        logic [15:0] c_lu;
        logic [15:0] c_fl;
    } exp_t;

    // Output pattern per cause: {stall PC..MEM_WB, flush IF_ID..MEM_WB, pc_redirect}
    localparam int C_RESET = 0, C_HALT = 1, C_MEM = 2, C_MISP = 3,
                   C_LU = 4, C_JUMP = 5, C_FETCH = 6, C_NONE = 7;
    localparam logic [9:0] PAT [0:7] = '{
        10'b00000_1111_0, 10'b11111_0000_0, 10'b11110_0001_0, 10'b00000_1100_1,
        10'b11000_0100_0, 10'b00000_1000_0, 10'b10000_1000_0, 10'b00000_0000_0
    };

    logic clk;
    logic reset;
    hazard_control_if hc_if();
`ifdef HAZARD_STATS_EN
    logic [15:0] mem_stall_cnt, lu_stall_cnt, flush_cnt;
`endif

    hazard_control dut (
        .clk(clk),
        .reset(reset),
        .hc(hc_if)
`ifdef HAZARD_STATS_EN
        ,
        .mem_stall_cnt(mem_stall_cnt),
        .lu_stall_cnt(lu_stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t  exp_q[$];
    int    checks = 0;
    int    fails  = 0;
    int    cyc    = 0;

    // Reference model: memory-wait flag, halt flag, counters.
    bit          m_wait = 1'b0;
    bit          m_halt = 1'b0;
    int          m_mem = 0, m_lu = 0, m_fl = 0;
    stim_t       prev_s;
    int          prev_cause;

    function automatic int cause_of(stim_t s, bit w, bit h);
        bit lu;
        lu = s.d_read && s.reg_write &&
             ((s.use_rs && s.rs == s.wr) || (s.use_rt && s.rt == s.wr));
        if (s.reset)                      return C_RESET;
        if (h)                            return C_HALT;
        if (w || (s.req && !s.dready))    return C_MEM;
        if (s.misp)                       return C_MISP;
        if (lu)                           return C_LU;
        if (s.jump)                       return C_JUMP;
        if (!s.imem_ready)                return C_FETCH;
        return C_NONE;
    endfunction

    function automatic int sat(int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.imem_ready = 1'b1;
        s.dready     = 1'b1;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        int   c;
        @(posedge clk);
        #1;
        if (prev_s.reset) begin
            m_wait = 1'b0;
            m_halt = 1'b0;
        end else begin
            if (!m_halt) begin
                if (prev_cause == C_MEM)                          m_mem = sat(m_mem);
                if (prev_cause == C_LU)                           m_lu  = sat(m_lu);
                if (prev_cause == C_MISP || prev_cause == C_JUMP) m_fl  = sat(m_fl);
            end
            if (prev_s.halt_wb || m_halt) begin
                m_halt = 1'b1;
                m_wait = 1'b0;
            end else if (m_wait) begin
                m_wait = !prev_s.dready;
            end else begin
                m_wait = prev_s.req && !prev_s.dready;
            end
        end
        if (s.reset) begin
            m_wait = 1'b0;
            m_halt = 1'b0;
            m_mem = 0; m_lu = 0; m_fl = 0;
        end
        reset                      = s.reset;
        hc_if.rs_ID                = s.rs;
        hc_if.rt_ID                = s.rt;
        hc_if.use_rs_ID            = s.use_rs;
        hc_if.use_rt_ID            = s.use_rt;
        hc_if.d_readM_EX           = s.d_read;
        hc_if.RegWrite_EX          = s.reg_write;
        hc_if.write_reg_addr_EX    = s.wr;
        hc_if.mispredict_EX        = s.misp;
        hc_if.isJump_ID            = s.jump;
        hc_if.i_mem_ready          = s.imem_ready;
        hc_if.d_mem_req_MEM        = s.req;
        hc_if.d_mem_ready          = s.dready;
        hc_if.is_halted_WB         = s.halt_wb;
        c        = cause_of(s, m_wait, m_halt);
        e.outs   = PAT[c];
        e.st     = m_halt ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
        e.hl     = m_halt;
        e.c_mem  = m_mem[15:0];
        e.c_lu   = m_lu[15:0];
        e.c_fl   = m_fl[15:0];
        exp_q.push_back(e);
        prev_s     = s;
        prev_cause = c;
        cyc++;
    endtask

    // Monitor: every cycle the DUT presents combinational outputs, compare mid-cycle.
    initial begin
        exp_t       e;
        logic [9:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {hc_if.stall_PC, hc_if.stall_IF_ID, hc_if.stall_ID_EX,
                       hc_if.stall_EX_MEM, hc_if.stall_MEM_WB, hc_if.flush_IF_ID,
                       hc_if.flush_ID_EX, hc_if.flush_EX_MEM, hc_if.flush_MEM_WB,
                       hc_if.pc_redirect};
                checks++;
                if (got !== e.outs) begin
                    fails++;
                    $display("FAIL outputs cyc %0d got %b required %b", cyc, got, e.outs);
                end
                checks++;
                if (hc_if.state !== e.st) begin
                    fails++;
                    $display("FAIL state cyc %0d got %0d required %0d", cyc, hc_if.state, e.st);
                end
                checks++;
                if (hc_if.halted !== e.hl) begin
                    fails++;
                    $display("FAIL halted cyc %0d got %b required %b", cyc, hc_if.halted, e.hl);
                end
`ifdef HAZARD_STATS_EN
                checks++;
                if ({mem_stall_cnt, lu_stall_cnt, flush_cnt} !== {e.c_mem, e.c_lu, e.c_fl}) begin
                    fails++;
                    $display("FAIL counters cyc %0d got %h/%h/%h required %h/%h/%h", cyc,
                             mem_stall_cnt, lu_stall_cnt, flush_cnt, e.c_mem, e.c_lu, e.c_fl);
                end
`endif
            end
        end
    end

    initial begin
        stim_t s;
        s = idle();
        s.reset = 1'b1;
        prev_s = s;
        prev_cause = C_RESET;
        reset = 1'b1;
        hc_if.rs_ID = 2'd0; hc_if.rt_ID = 2'd0; hc_if.use_rs_ID = 1'b0; hc_if.use_rt_ID = 1'b0;
        hc_if.d_readM_EX = 1'b0; hc_if.RegWrite_EX = 1'b0; hc_if.write_reg_addr_EX = 2'd0;
        hc_if.mispredict_EX = 1'b0; hc_if.isJump_ID = 1'b0; hc_if.i_mem_ready = 1'b1;
        hc_if.d_mem_req_MEM = 1'b0; hc_if.d_mem_ready = 1'b1; hc_if.is_halted_WB = 1'b0;

        repeat (2) step(s);
        step(idle());

        // Memory wait: three not-ready cycles, then ready.
        s = idle(); s.req = 1'b1; s.dready = 1'b0;
        repeat (3) step(s);
        s.dready = 1'b1;
        step(s);
        step(idle());

        // Load-use on rs, then the same without use_rs.
        s = idle(); s.d_read = 1'b1; s.reg_write = 1'b1; s.wr = 2'd2; s.rs = 2'd2; s.use_rs = 1'b1;
        step(s);
        s.use_rs = 1'b0;
        step(s);

        // Mispredict beats load-use.
        s.use_rs = 1'b1; s.misp = 1'b1;
        step(s);

        // Mispredict held across a memory wait is serviced on the first RUN cycle.
        s = idle(); s.misp = 1'b1; s.req = 1'b1; s.dready = 1'b0;
        repeat (2) step(s);
        s.dready = 1'b1;
        step(s);
        s.req = 1'b0;
        step(s);

        // Jump beats fetch wait; fetch wait alone.
        s = idle(); s.jump = 1'b1; s.imem_ready = 1'b0;
        step(s);
        s.jump = 1'b0;
        step(s);

        // Halt from mid memory wait, sticky, then async reset.
        s = idle(); s.req = 1'b1; s.dready = 1'b0;
        step(s);
        s.halt_wb = 1'b1;
        step(s);
        s = idle(); s.misp = 1'b1;
        repeat (4) step(s);
        s = idle(); s.reset = 1'b1;
        step(s);
        step(idle());

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            s.rs         = 2'($urandom_range(0, 3));
            s.rt         = 2'($urandom_range(0, 3));
            s.wr         = 2'($urandom_range(0, 3));
            s.use_rs     = 1'($urandom_range(0, 1));
            s.use_rt     = 1'($urandom_range(0, 1));
            s.d_read     = 1'($urandom_range(0, 1));
            s.reg_write  = 1'($urandom_range(0, 1));
            s.misp       = ($urandom_range(0, 5) == 0);
            s.jump       = ($urandom_range(0, 4) == 0);
            s.imem_ready = ($urandom_range(0, 3) != 0);
            s.req        = ($urandom_range(0, 3) == 0);
            s.dready     = ($urandom_range(0, 3) != 0);
            s.halt_wb    = ($urandom_range(0, 199) == 0);
            s.reset      = m_halt ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 149) == 0);
            step(s);
        end
        s = idle(); s.reset = 1'b1;
        step(s);
        step(idle());

`ifdef HAZARD_STATS_EN
        // Long memory wait saturates the memory-stall counter.
        s = idle(); s.req = 1'b1; s.dready = 1'b0;
        repeat (70000) step(s);
        step(idle());
`endif

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
